// File: rtl/noc_tb_seq.sv
// Mesh NoC bench sequencer: reset hold, injection gating, packet accounting.
// Optional NOC_TB_LATENCY_EN adds lat_acc (sum of outstanding per active cycle).
module noc_tb_seq #(
  parameter int DIMX     = 4,
  parameter int DIMY     = 3,
  parameter int RST_CYC  = 133,
  parameter int PKT_NUM  = 16,
  parameter int CW       = 16,
  parameter int TOUT_CYC = 65535,
  localparam int NODES   = DIMX * DIMY,
  localparam int TW      = CW + $clog2(NODES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NODES-1:0] pkt_sent,
  input  logic [NODES-1:0] pkt_recv,
  output logic             noc_rst_n,
  output logic [NODES-1:0] inj_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err,
  output logic [TW-1:0]    sent_total,
  output logic [TW-1:0]    recv_total,
  output logic [TW-1:0]    outstanding,
  output logic [TW-1:0]    cycles
`ifdef NOC_TB_LATENCY_EN
  ,
  output logic [TW+CW-1:0] lat_acc
`endif
);

  localparam int RW = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_RUN, S_DRAIN, S_DONE, S_TOUT
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rst_cnt;
  logic [CW-1:0]    node_cnt [NODES];
  logic [CW-1:0]    cnt_d [NODES];
  logic [NODES-1:0] sent_v, inj_d, full;
  logic [TW-1:0]    sent_n, recv_n, recv_ok_n, cyc_d;
  logic [TW:0]      avail;
  logic             active, go, recv_bad, err_now, all_full;
  logic             nrst_d, busy_d, done_d, tout_d;

  function automatic logic [TW-1:0] popcnt(input logic [NODES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NODES; i++)
      popcnt = popcnt + TW'(v[i]);
  endfunction

  always_comb begin : datapath
    active = (state_q == S_RUN) || (state_q == S_DRAIN);
    go = start && ((state_q == S_IDLE) || (state_q == S_DONE)
                   || (state_q == S_TOUT));
    sent_v = active ? (pkt_sent & inj_en) : '0;
    sent_n = popcnt(sent_v);
    recv_n = popcnt(pkt_recv);
    // receives may retire packets injected in the same cycle
    avail = {1'b0, outstanding} + {1'b0, sent_n};
    recv_bad = active && ({1'b0, recv_n} > avail);
    recv_ok_n = (active && !recv_bad) ? recv_n : '0;
    err_now = (|(pkt_sent & ~inj_en)) || (!active && (|pkt_recv))
              || recv_bad;
    for (int i = 0; i < NODES; i++) begin
      cnt_d[i] = node_cnt[i] + CW'(sent_v[i]);
      full[i] = (node_cnt[i] == CW'(PKT_NUM));
    end
    all_full = &full;
    cyc_d = (active && (cycles < TW'(TOUT_CYC))) ? cycles + TW'(1) : cycles;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_TOUT:
        if (start) state_d = S_RST;
      S_RST:
        if (rst_cnt == RW'(RST_CYC - 1)) state_d = S_RUN;
      S_RUN:
        if (cyc_d >= TW'(TOUT_CYC)) state_d = S_TOUT;
        else if (all_full) state_d = S_DRAIN;
      S_DRAIN:
        if (cyc_d >= TW'(TOUT_CYC)) state_d = S_TOUT;
        else if (outstanding == '0) state_d = S_DONE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs_d
    nrst_d = !((state_d == S_IDLE) || (state_d == S_RST));
    busy_d = (state_d == S_RST) || (state_d == S_RUN)
             || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    tout_d = (state_d == S_TOUT);
    for (int i = 0; i < NODES; i++)
      inj_d[i] = (state_d == S_RUN) && (cnt_d[i] < CW'(PKT_NUM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      noc_rst_n   <= 1'b0;
      inj_en      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      err         <= 1'b0;
      rst_cnt     <= '0;
      sent_total  <= '0;
      recv_total  <= '0;
      outstanding <= '0;
      cycles      <= '0;
      for (int i = 0; i < NODES; i++) node_cnt[i] <= '0;
    end else begin
      state_q   <= state_d;
      noc_rst_n <= nrst_d;
      inj_en    <= inj_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= tout_d;
      if (go) begin
        err         <= 1'b0;
        rst_cnt     <= '0;
        sent_total  <= '0;
        recv_total  <= '0;
        outstanding <= '0;
        cycles      <= '0;
        for (int i = 0; i < NODES; i++) node_cnt[i] <= '0;
      end else begin
        err <= err | err_now;
        if (state_q == S_RST) rst_cnt <= rst_cnt + RW'(1);
        if (active) begin
          sent_total  <= sent_total + sent_n;
          recv_total  <= recv_total + recv_ok_n;
          outstanding <= outstanding + sent_n - recv_ok_n;
          cycles      <= cyc_d;
          for (int i = 0; i < NODES; i++) node_cnt[i] <= cnt_d[i];
        end
      end
    end
  end

`ifdef NOC_TB_LATENCY_EN
  logic [TW+CW:0] lat_sum;
  assign lat_sum = {1'b0, lat_acc} + (TW+CW+1)'(outstanding);

  always_ff @(posedge clk) begin
    if (rst || go)
      lat_acc <= '0;
    else if (active)
      lat_acc <= lat_sum[TW+CW] ? '1 : lat_sum[TW+CW-1:0];
  end
`endif

endmodule

// File: tb/tb_noc_tb_seq.sv
// Directed bench for noc_tb_seq: reset hold, traffic, errors, timeout.
module tb_noc_tb_seq;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [11:0]   pkt_sent = '0;
  logic [11:0]   pkt_recv = '0;
  logic          noc_rst_n, busy, done, timeout, err;
  logic [11:0]   inj_en;
  logic [TW-1:0] sent_total, recv_total, outstanding, cycles;
`ifdef NOC_TB_LATENCY_EN
  logic [TW+15:0] lat_acc;
`endif

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  noc_tb_seq #(
    .DIMX(4), .DIMY(3), .RST_CYC(133), .PKT_NUM(16),
    .CW(16), .TOUT_CYC(65535)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pkt_sent(pkt_sent), .pkt_recv(pkt_recv),
    .noc_rst_n(noc_rst_n), .inj_en(inj_en),
    .busy(busy), .done(done), .timeout(timeout), .err(err),
    .sent_total(sent_total), .recv_total(recv_total),
    .outstanding(outstanding), .cycles(cycles)
`ifdef NOC_TB_LATENCY_EN
    , .lat_acc(lat_acc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (noc_rst_n !== 1'b1 && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (noc_rst_n !== 1'b0 || inj_en !== 12'h000)
      $display("FAIL reset_nrst_inj: got %b %h want 0 000", noc_rst_n, inj_en);
    else pass++;
    total++;
    if ({busy, done, timeout, err} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, done, timeout, err});
    else pass++;
    total++;
    if (sent_total !== 0 || recv_total !== 0 || outstanding !== 0 || cycles !== 0)
      $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0 0 0 0",
               sent_total, recv_total, outstanding, cycles);
    else pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_rst_len();
    int n;
    pulse_start();
    total++;
    if (busy !== 1'b1)
      $display("FAIL rst_busy: got %b want 1", busy);
    else pass++;
    wait_run(n);
    total++;
    if (n != 133)
      $display("FAIL rst_len: got %0d want 133", n);
    else pass++;
    total++;
    if (inj_en !== 12'hFFF)
      $display("FAIL run_inj_en: got %h want fff", inj_en);
    else pass++;
  endtask

  task automatic test_traffic();
    int n;
    pkt_sent = 12'hFFF;
    step();
    total++;
    if (outstanding !== 12 || sent_total !== 12)
      $display("FAIL first_burst: got %0d %0d want 12 12", outstanding, sent_total);
    else pass++;
    pkt_recv = 12'hFFF;
    step();
    total++;
    if (outstanding !== 12 || recv_total !== 12 || sent_total !== 24)
      $display("FAIL simul_12: got %0d %0d %0d want 12 12 24",
               outstanding, recv_total, sent_total);
    else pass++;
    repeat (14) step();
    total++;
    if (inj_en !== 12'h000 || sent_total !== 192)
      $display("FAIL inj_drop: got %h %0d want 000 192", inj_en, sent_total);
    else pass++;
    pkt_sent = '0;
    step();
    pkt_recv = '0;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      n++;
      step();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL run_done: got done=%b busy=%b err=%b want 1 0 0", done, busy, err);
    else pass++;
    total++;
    if (sent_total !== 192 || recv_total !== 192 || outstanding !== 0)
      $display("FAIL run_totals: got %0d %0d %0d want 192 192 0",
               sent_total, recv_total, outstanding);
    else pass++;
    total++;
    if (cycles !== 18 || noc_rst_n !== 1'b1)
      $display("FAIL run_cycles: got %0d nrst=%b want 18 1", cycles, noc_rst_n);
    else pass++;
  endtask

  task automatic test_err_recv();
    int n;
    pulse_start();
    wait_run(n);
    total++;
    if (noc_rst_n !== 1'b1 || err !== 1'b0 || sent_total !== 0)
      $display("FAIL rerun: got nrst=%b err=%b sent=%0d want 1 0 0",
               noc_rst_n, err, sent_total);
    else pass++;
    pkt_recv = 12'h001;
    step();
    pkt_recv = '0;
    total++;
    if (err !== 1'b1 || recv_total !== 0 || outstanding !== 0)
      $display("FAIL err_recv: got err=%b recv=%0d out=%0d want 1 0 0",
               err, recv_total, outstanding);
    else pass++;
  endtask

  task automatic test_start_ignored();
    pulse_start();
    total++;
    if (busy !== 1'b1 || noc_rst_n !== 1'b1 || err !== 1'b1)
      $display("FAIL start_ignored: got busy=%b nrst=%b err=%b want 1 1 1",
               busy, noc_rst_n, err);
    else pass++;
    pkt_sent = 12'hFFF;
    step();
    pkt_sent = '0;
    total++;
    if (sent_total !== 12 || outstanding !== 12)
      $display("FAIL run_after_start: got %0d %0d want 12 12", sent_total, outstanding);
    else pass++;
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    step();
    total++;
    if (noc_rst_n !== 1'b0 || inj_en !== 12'h000 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_rst_flags: got nrst=%b inj=%h busy=%b err=%b want 0 000 0 0",
               noc_rst_n, inj_en, busy, err);
    else pass++;
    total++;
    if (sent_total !== 0 || outstanding !== 0 || cycles !== 0)
      $display("FAIL mid_rst_cnt: got %0d %0d %0d want 0 0 0",
               sent_total, outstanding, cycles);
    else pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_err_sent();
    int n;
    pulse_start();
    wait_run(n);
    total++;
    if (n != 133 || err !== 1'b0)
      $display("FAIL rerun_len: got %0d err=%b want 133 0", n, err);
    else pass++;
    pkt_sent = 12'h008;
    repeat (16) step();
    total++;
    if (inj_en !== 12'hFF7 || sent_total !== 16 || err !== 1'b0)
      $display("FAIL node3_full: got %h %0d err=%b want ff7 16 0",
               inj_en, sent_total, err);
    else pass++;
    step();
    pkt_sent = '0;
    total++;
    if (err !== 1'b1 || sent_total !== 16 || outstanding !== 16)
      $display("FAIL err_sent: got err=%b %0d %0d want 1 16 16",
               err, sent_total, outstanding);
    else pass++;
  endtask

  task automatic test_timeout();
    int n;
    pkt_sent = 12'hFF7;
    repeat (16) step();
    pkt_sent = '0;
    pkt_recv = 12'hFDF;
    repeat (16) step();
    pkt_recv = '0;
    total++;
    if (sent_total !== 192 || recv_total !== 176 || outstanding !== 16)
      $display("FAIL drain_stuck: got %0d %0d %0d want 192 176 16",
               sent_total, recv_total, outstanding);
    else pass++;
    step();
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL drain_busy: got busy=%b done=%b want 1 0", busy, done);
    else pass++;
    n = 0;
    while (timeout !== 1'b1 && n < 70000) begin
      n++;
      step();
    end
    total++;
    if (timeout !== 1'b1 || cycles !== 20'd65535)
      $display("FAIL timeout: got tout=%b cycles=%0d want 1 65535", timeout, cycles);
    else pass++;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1)
      $display("FAIL tout_flags: got done=%b busy=%b err=%b want 0 0 1",
               done, busy, err);
    else pass++;
  endtask

  task automatic test_restart();
    pulse_start();
    total++;
    if (err !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1 || noc_rst_n !== 1'b0)
      $display("FAIL restart_flags: got err=%b tout=%b busy=%b nrst=%b want 0 0 1 0",
               err, timeout, busy, noc_rst_n);
    else pass++;
    total++;
    if (sent_total !== 0 || recv_total !== 0 || outstanding !== 0 || cycles !== 0)
      $display("FAIL restart_cnt: got %0d %0d %0d %0d want 0 0 0 0",
               sent_total, recv_total, outstanding, cycles);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_rst_len();
    test_traffic();
    test_err_recv();
    test_start_ignored();
    test_rst_mid();
    test_err_sent();
    test_timeout();
    test_restart();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
